// File: rtl/fadd_issue_arbiter_pkg.sv
// Shared types and FP32 field constants for the FP add issue arbiter.
// Provides the denormals-are-zero helper used when FADD_ARB_DAZ_EN is defined.
package fadd_issue_arbiter_pkg;

    localparam int          FP_W          = 32;
    localparam int          FP_SIGN_BIT   = 31;
    localparam int          FP_EXP_MSB    = 30;
    localparam int          FP_EXP_LSB    = 23;
    localparam logic [7:0]  FP_EXP_DENORM = 8'h00;
    localparam logic [7:0]  FP_EXP_INFNAN = 8'hFF;
    localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
    localparam logic [31:0] FP_SIGN_MASK  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    // Zero exponent means denormal or zero: flush to a signed zero.
    function automatic logic [31:0] fp_daz(input logic [31:0] x);
        if (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_DENORM) begin
            return (x & FP_SIGN_MASK) | FP_ZERO;
        end
        return x;
    endfunction

endpackage

// File: rtl/fadd_result_fifo.sv
// Order-preserving result FIFO with occupancy count; push+pop on full is legal.
// Pop on empty is ignored; head data reads as zero while empty.
module fadd_result_fifo
    import fadd_issue_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fadd_issue_arbiter.sv
// Round-robin issue of lane FP add requests onto one shared ADD_LAT-deep adder.
// Option macro FADD_ARB_DAZ_EN: flush denormal operands to signed zero at issue.
//   state    | meaning
//   ST_RUN   | normal issue, grants allowed when credits permit
//   ST_DRAIN | no grants; wait for issue reg, tag pipe and FIFO to empty
//   ST_DONE  | drained (drain_done_o=1); hold until drain_req_i drops
module fadd_issue_arbiter
    import fadd_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADD_LAT   = 3,
    parameter int RES_DEPTH = 8,
    parameter int TAG_W     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [32*NUM_REQ-1:0]   req_a_i,
    input  logic [32*NUM_REQ-1:0]   req_b_i,
    output logic                    add_valid_o,
    output logic [31:0]             add_a_o,
    output logic [31:0]             add_b_o,
    input  logic [31:0]             add_out_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [TAG_W-1:0]        resp_tag_o,
    output logic [31:0]             resp_data_o,
    input  logic                    drain_req_i,
    output logic                    drain_done_o,
    output logic                    busy_o
);

    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
    localparam int OCC_W  = $clog2(RES_DEPTH + ADD_LAT + 2) + 1;
    localparam int FIFO_W = TAG_W + 32;

    arb_state_e                    state_q, state_d;
    logic [TAG_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          issue_q;
    logic [TAG_W-1:0]              issue_tag_q;
    logic [31:0]                   add_a_q, add_b_q;
    logic [ADD_LAT-1:0]            pipe_vld_q;
    logic [ADD_LAT-1:0][TAG_W-1:0] pipe_tag_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [FIFO_W-1:0]  fifo_rdata;
    logic [OCC_W-1:0]   occ;
    logic               credit_ok, grant_any, busy;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic [31:0]        sel_a, sel_b, iss_a, iss_b;

    // Everything already committed to the FIFO counts against its depth.
    always_comb begin
        occ = OCC_W'(fifo_count) + OCC_W'(issue_q);
        for (int k = 0; k < ADD_LAT; k++) begin
            occ = occ + OCC_W'(pipe_vld_q[k]);
        end
    end

    assign credit_ok = (occ < OCC_W'(RES_DEPTH));
    assign busy      = issue_q | (|pipe_vld_q) | (fifo_count != '0);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (rst_n && (state_q == ST_RUN) && credit_ok) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = (int'(rr_ptr_q) + off) % NUM_REQ;
                if (!grant_any && req_valid_i[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'(idx);
                end
            end
            if (grant_any) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    assign rr_ptr_d = !grant_any ? rr_ptr_q :
                      (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign sel_a = req_a_i[32*grant_idx +: 32];
    assign sel_b = req_b_i[32*grant_idx +: 32];

`ifdef FADD_ARB_DAZ_EN
    assign iss_a = fp_daz(sel_a);
    assign iss_b = fp_daz(sel_b);
`else
    assign iss_a = sel_a;
    assign iss_b = sel_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            issue_q     <= 1'b0;
            issue_tag_q <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            issue_q  <= grant_any;
            if (grant_any) begin
                issue_tag_q <= grant_idx;
                add_a_q     <= iss_a;
                add_b_q     <= iss_b;
            end
        end
    end

    // Tag pipe: stage ADD_LAT-1 lines up with add_out_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_vld_q[0] <= issue_q;
            pipe_tag_q[0] <= issue_tag_q;
            for (int k = 1; k < ADD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
        end
    end

    fadd_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FIFO_W)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pipe_vld_q[ADD_LAT-1]),
        .wdata_i ({pipe_tag_q[ADD_LAT-1], add_out_i}),
        .pop_i   (resp_ready_i),
        .valid_o (resp_valid_o),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A drain_req_i pulse only needs to be seen once in ST_RUN.
    always_comb begin
        state_d      = state_q;
        drain_done_o = 1'b0;
        unique case (state_q)
            ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
            ST_DRAIN: if (!busy)       state_d = ST_DONE;
            ST_DONE: begin
                drain_done_o = 1'b1;
                if (!drain_req_i) state_d = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    assign req_ready_o = grant;
    assign add_valid_o = issue_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign resp_tag_o  = fifo_rdata[FIFO_W-1:32];
    assign resp_data_o = fifo_rdata[31:0];
    assign busy_o      = busy;

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Directed-vector bench for fadd_issue_arbiter with a behavioural FP32 adder model.
module tb_fadd_issue_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADD_LAT   = 3;
    localparam int RES_DEPTH = 8;
    localparam int TAG_W     = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a, req_b;
    logic                  add_valid;
    logic [31:0]           add_a, add_b, add_out;
    logic                  resp_valid, resp_ready;
    logic [TAG_W-1:0]      resp_tag;
    logic [31:0]           resp_data;
    logic                  drain_req, drain_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fadd_issue_arbiter #(
        .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .add_valid_o(add_valid), .add_a_o(add_a), .add_b_o(add_b), .add_out_i(add_out),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_tag_o(resp_tag), .resp_data_o(resp_data),
        .drain_req_i(drain_req), .drain_done_o(drain_done), .busy_o(busy)
    );

    function automatic logic [31:0] fp_add_model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, t;
        logic [49:0] xa, xb, s;
        int ea, eb, e;
        if (x[30:0] == 31'h0) return y;
        if (y[30:0] == 31'h0) return x;
        a = x; b = y;
        if (b[30:0] > a[30:0]) begin t = a; a = b; b = t; end
        ea = (a[30:23] == 8'h0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'h0) ? 1 : int'(b[30:23]);
        xa = {26'b0, (a[30:23] != 8'h0), a[22:0]} << 24;
        xb = ({26'b0, (b[30:23] != 8'h0), b[22:0]} << 24) >> (ea - eb);
        s  = (a[31] == b[31]) ? xa + xb : xa - xb;
        if (s == 50'h0) return 32'h0;
        e = ea;
        while (s[48]) begin s = s >> 1; e++; end
        while (!s[47] && e > 1) begin s = s << 1; e--; end
        if (!s[47]) e = 0;
        return {a[31], 8'(e), s[46:24]};
    endfunction

    logic [31:0] mdl_pipe [ADD_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ADD_LAT; k++) mdl_pipe[k] <= 32'h0;
        end else begin
            mdl_pipe[0] <= add_valid ? fp_add_model(add_a, add_b) : 32'h0;
            for (int k = 1; k < ADD_LAT; k++) mdl_pipe[k] <= mdl_pipe[k-1];
        end
    end
    assign add_out = mdl_pipe[ADD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        drain_req  = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"},  64'(req_ready),  64'h0);
        chk({pfx, "_add_valid"},  64'(add_valid),  64'h0);
        chk({pfx, "_add_a"},      64'(add_a),      64'h0);
        chk({pfx, "_add_b"},      64'(add_b),      64'h0);
        chk({pfx, "_resp_valid"}, 64'(resp_valid), 64'h0);
        chk({pfx, "_resp_tag"},   64'(resp_tag),   64'h0);
        chk({pfx, "_resp_data"},  64'(resp_data),  64'h0);
        chk({pfx, "_drain_done"}, 64'(drain_done), 64'h0);
        chk({pfx, "_busy"},       64'(busy),       64'h0);
    endtask

    logic [31:0] exp_res [NUM_REQ];
    logic [31:0] daz_exp_a;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrx, ngr;
        bit done;
        exp_res[0] = 32'h4000_0000;
        exp_res[1] = 32'h4040_0000;
        exp_res[2] = 32'h4080_0000;
        exp_res[3] = 32'h40A0_0000;
        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0;
        resp_ready = 1'b0; drain_req = 1'b0;
        #12;
        check_reset_outputs("rst");
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // single op
        set_ops(0, 32'h3F80_0000, 32'h4000_0000);
        @(posedge clk); #1 req_valid = 4'b0001; resp_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'h1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("single_add_valid", 64'(add_valid), 64'h1);
        chk("single_add_a", 64'(add_a), 64'h3F80_0000);
        chk("single_add_b", 64'(add_b), 64'h4000_0000);
        chk("single_busy", 64'(busy), 64'h1);
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("single_resp_valid", 64'(resp_valid), 64'(c == ADD_LAT + 2));
            if (c == 2) chk("single_add_valid_off", 64'(add_valid), 64'h0);
            if (c == ADD_LAT + 2) begin
                chk("single_tag", 64'(resp_tag), 64'h0);
                chk("single_data", 64'(resp_data), 64'h4040_0000);
            end
            if (c == 6) chk("single_idle", 64'(busy), 64'h0);
        end

        // fairness
        do_reset();
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
        set_ops(1, 32'h4000_0000, 32'h3F80_0000);
        set_ops(2, 32'h4040_0000, 32'h3F80_0000);
        set_ops(3, 32'h4080_0000, 32'h3F80_0000);
        resp_ready = 1'b1;
        nrx = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1 req_valid = (c < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (c < 8) chk("rr_grant", 64'(req_ready), 64'(1 << (c % 4)));
            if (resp_valid) begin
                chk("rr_tag", 64'(resp_tag), 64'(nrx % 4));
                chk("rr_data", 64'(resp_data), 64'(exp_res[nrx % 4]));
                nrx++;
            end
        end
        chk("rr_count", 64'(nrx), 64'd8);

        // backpressure
        do_reset();
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
        ngr = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1 req_valid = 4'b0001;
            @(negedge clk);
            if (req_ready[0]) ngr++;
        end
        chk("bp_grants", 64'(ngr), 64'(RES_DEPTH));
        chk("bp_full_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_valid", 64'(resp_valid), 64'h1);
        chk("bp_samecycle_pop", 64'(req_ready), 64'h0);
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_regrant", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_refull", 64'(req_ready), 64'h0);
        @(posedge clk); #1 req_valid = '0; resp_ready = 1'b1;
        nrx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nrx == 0) chk("bp_data", 64'(resp_data), 64'h4000_0000);
                nrx++;
            end
        end
        chk("bp_rx_count", 64'(nrx), 64'(RES_DEPTH));
        chk("bp_idle", 64'(busy), 64'h0);

        // drain
        do_reset();
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
        set_ops(1, 32'h4000_0000, 32'h3F80_0000);
        set_ops(2, 32'h4040_0000, 32'h3F80_0000);
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1 req_valid = 4'b0111;
            @(negedge clk);
            chk("drain_pre_grant", 64'(req_ready), 64'(1 << c));
        end
        @(posedge clk); #1 req_valid = '0; drain_req = 1'b1;
        @(posedge clk); #1 drain_req = 1'b0; req_valid = 4'hF;
        nrx = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (drain_done) done = 1;
            else chk("drain_nogrant", 64'(req_ready), 64'h0);
            if (resp_valid) begin
                chk("drain_tag", 64'(resp_tag), 64'(nrx));
                chk("drain_data", 64'(resp_data), 64'(exp_res[nrx % 4]));
                nrx++;
            end
        end
        chk("drain_done_seen", 64'(done), 64'h1);
        chk("drain_rx_count", 64'(nrx), 64'd3);
        @(negedge clk);
        chk("drain_release", 64'(drain_done), 64'h0);
        chk("drain_resume", 64'(req_ready), 64'h8);
        @(posedge clk); #1 req_valid = '0;

        // DAZ / passthrough
        do_reset();
`ifdef FADD_ARB_DAZ_EN
        daz_exp_a = 32'h8000_0000;
`else
        daz_exp_a = 32'h8000_0001;
`endif
        set_ops(0, 32'h8000_0001, 32'h3F80_0000);
        resp_ready = 1'b1;
        @(posedge clk); #1 req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("daz_add_a", 64'(add_a), 64'(daz_exp_a));
        chk("daz_add_b", 64'(add_b), 64'h3F80_0000);
        for (int c = 2; c <= ADD_LAT + 2; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("daz_resp_valid", 64'(resp_valid), 64'h1);
        chk("daz_data", 64'(resp_data), 64'h3F80_0000);

        // async reset mid-stream
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 req_valid = 4'hF;
        end
        @(posedge clk); #1;
        chk("pre_rst_resp", 64'(resp_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); @(posedge clk); #1;
        req_valid = '0; resp_ready = 1'b1; rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(resp_valid), 64'h0);
        end
        chk("rst_idle", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
